// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle sequencer for the NCR 53C710 DMA path.
// Ports: CLK/RST; BMASTER grant; req + req_addr/req_read/req_siz from the NCR;
//   async DTACK_n/BERR_n in; ADDR_OE, FCS_n, DS_n[3:0], DOE, READ_OUT drive Zorro;
//   data_latch/done/berr are one-cycle pulses back to the NCR; busy = not idle.
module z3_master_cycle #(
    parameter int ADDR_SETUP  = 1,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BMASTER,
    input  logic       req,
    input  logic [1:0] req_addr,
    input  logic       req_read,
    input  logic [1:0] req_siz,
    input  logic       DTACK_n,
    input  logic       BERR_n,
    output logic       ADDR_OE,
    output logic       FCS_n,
    output logic [3:0] DS_n,
    output logic       DOE,
    output logic       READ_OUT,
    output logic       data_latch,
    output logic       done,
    output logic       berr,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STROBE, S_DATA, S_TERM, S_REL
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q;
    logic                   rd_q;
    logic [3:0]             lanes_q, lanes_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] dt_sync_q, be_sync_q;
    logic                   dt_s, be_s;

    assign dt_s = dt_sync_q[SYNC_STAGES-1];
    assign be_s = be_sync_q[SYNC_STAGES-1];

    // Async Zorro handshakes pass through a flop chain before the FSM looks at them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dt_sync_q <= '1;
            be_sync_q <= '1;
        end else begin
            dt_sync_q[0] <= DTACK_n;
            be_sync_q[0] <= BERR_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dt_sync_q[i] <= dt_sync_q[i-1];
                be_sync_q[i] <= be_sync_q[i-1];
            end
        end
    end

    // Byte lane i (DS_n[3-i]) is active for o <= i < o+n; lanes past 3 fall off.
    always_comb begin
        logic [2:0] n;
        lanes_d = '0;
        n = (req_siz == 2'd0) ? 3'd4 : {1'b0, req_siz};
        for (int i = 0; i < 4; i++) begin
            lanes_d[3-i] = (3'(i) >= {1'b0, req_addr}) &&
                           (3'(i) < ({1'b0, req_addr} + n));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && BMASTER) begin
                    state_d = S_ADDR;
                    err_d   = 1'b0;
                end
            end
            S_ADDR: begin
                if (!BMASTER) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (!BMASTER) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Grant loss and BERR outrank DTACK; DTACK outranks timeout.
                if (!BMASTER || !be_s) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end else if (!dt_s) begin
                    state_d = S_TERM;
                    err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end
            end
            S_TERM: state_d = S_REL;
            S_REL: begin
                if (!req && dt_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The counter restarts on every state change: setup count in ADDR,
    // timeout count in DATA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            lanes_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
            err_q <= err_d;
            if (state_q == S_IDLE && state_d == S_ADDR) begin
                rd_q    <= req_read;
                lanes_q <= lanes_d;
            end
        end
    end

    always_comb begin
        ADDR_OE    = 1'b0;
        FCS_n      = 1'b1;
        DS_n       = 4'hF;
        DOE        = 1'b0;
        READ_OUT   = 1'b1;
        data_latch = 1'b0;
        done       = 1'b0;
        berr       = 1'b0;
        busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_ADDR: begin
                ADDR_OE  = 1'b1;
                READ_OUT = rd_q;
            end
            S_STROBE, S_DATA: begin
                ADDR_OE  = 1'b1;
                READ_OUT = rd_q;
                FCS_n    = 1'b0;
                DS_n     = ~lanes_q;
                DOE      = 1'b1;
            end
            S_TERM: begin
                ADDR_OE    = 1'b1;
                READ_OUT   = rd_q;
                done       = !err_q;
                berr       = err_q;
                data_latch = !err_q && rd_q;
            end
            default: ;
        endcase
    end

endmodule
